// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  // Bit-sampler front-end states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    BITS      = 2'd2,
    WAIT_IDLE = 2'd3
  } uart_rx_samp_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  localparam int UART_MAX_FRAME_BITS     = 12;
  localparam int UART_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// rx line synchroniser with falling-edge detect.
// A valid bit travels alongside each synchroniser stage so that the
// idle-high values loaded on clear are never compared against real line
// data: a line that is already low when the block leaves clear produces
// no edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] vld_p;
  logic                   rx_s_d;
  logic                   vld_d;
  logic                   clear;

  assign clear = !rst_n || !enable;

  // Shift the line and its valid flag through the synchroniser and edge register.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync_p <= '1;
      vld_p  <= '0;
      rx_s_d <= 1'b1;
      vld_d  <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], rx_in};
      vld_p  <= {vld_p[SYNC_STAGES-2:0], 1'b1};
      rx_s_d <= sync_p[SYNC_STAGES-1];
      vld_d  <= vld_p[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_p[SYNC_STAGES-1];
  assign fall = vld_d && rx_s_d && !rx_s;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: finds the start bit, majority-votes three
// oversamples around each bit centre and hands one decided bit per bit
// period to the frame state machine.
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = UART_SYNC_STAGES_DEFAULT,
  parameter int MAX_BITS    = UART_MAX_FRAME_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic baud_tick,
  input  logic rx_in,
  input  logic frame_complete,
  output logic start_detected,
  output logic bit_valid,
  output logic bit_sample,
  output logic rx_busy,
  output logic false_start,
  output logic timeout_err
);

  localparam int MID    = OVERSAMPLE / 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(MAX_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(MID);
  localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(MID + 1);
  localparam logic [BIT_W-1:0]  BIT_LIMIT = BIT_W'(MAX_BITS);

  // Majority of three samples; with an odd count a tie cannot occur.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_rx_samp_state_t state, state_next;

  logic [TICK_W-1:0] tick_cnt, tick_next, tick_adv;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [1:0]        vote_p0, vote_next;
  logic              rx_s, fall;
  logic              sample_tick, decide, voted;
  logic              start_next, valid_next, sample_next, false_next, timeout_next;
  logic              clear;

  assign clear = !rst_n || !enable;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .rx_in  (rx_in),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  assign tick_adv    = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  assign sample_tick = baud_tick && ((tick_cnt == TICK_S0) || (tick_cnt == TICK_S1));
  assign decide      = baud_tick && (tick_cnt == TICK_S2);
  assign voted       = maj3(vote_p0[1], vote_p0[0], rx_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, counters, vote capture and registered-output next values.
  always_comb begin
    state_next   = state;
    tick_next    = tick_cnt;
    bit_cnt_next = bit_cnt;
    vote_next    = vote_p0;
    start_next   = 1'b0;
    valid_next   = 1'b0;
    sample_next  = bit_sample;
    false_next   = 1'b0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        tick_next    = '0;
        bit_cnt_next = '0;
        if (fall) state_next = START;
      end
      START: begin
        if (baud_tick)   tick_next = tick_adv;
        if (sample_tick) vote_next = {vote_p0[0], rx_s};
        if (decide) begin
          if (!voted) begin
            state_next = BITS;
            start_next = 1'b1;
          end else begin
            state_next = IDLE;
            false_next = 1'b1;
            tick_next  = '0;
          end
        end
      end
      BITS: begin
        if (frame_complete) begin
          // frame_complete outranks a bit decision landing in the same cycle.
          state_next   = WAIT_IDLE;
          bit_cnt_next = '0;
          tick_next    = '0;
        end else if (bit_cnt == BIT_LIMIT) begin
          state_next   = WAIT_IDLE;
          timeout_next = 1'b1;
          bit_cnt_next = '0;
          tick_next    = '0;
        end else begin
          if (baud_tick)   tick_next = tick_adv;
          if (sample_tick) vote_next = {vote_p0[0], rx_s};
          if (decide) begin
            valid_next   = 1'b1;
            sample_next  = voted;
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) parks here and cannot start a new frame.
        tick_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters and registered outputs, cleared by reset or disable.
  always_ff @(posedge clk) begin
    if (clear) begin
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      start_detected <= 1'b0;
      bit_valid      <= 1'b0;
      bit_sample     <= 1'b0;
      rx_busy        <= 1'b0;
      false_start    <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      tick_cnt       <= tick_next;
      bit_cnt        <= bit_cnt_next;
      start_detected <= start_next;
      bit_valid      <= valid_next;
      bit_sample     <= sample_next;
      rx_busy        <= (state_next != IDLE);
      false_start    <= false_next;
      timeout_err    <= timeout_next;
    end
  end

  // Oversample shift register; pure data, only meaningful between a start edge and a decision.
  always_ff @(posedge clk) begin
    vote_p0 <= vote_next;
  end

endmodule
